ff_bank: RTL and testbench

Parametrised bank of WIDTH flip-flops with a run-time selectable behaviour: D, T, SR or JK. It generalises the single SR-over-T flip-flop into a multi-bit register. Additions over the single flip-flop are a configurable reset value, a global update enable, illegal-SR detection with per-bit sticky error flags, and a registered change indicator. It sits wherever control logic needs a small bank of bistable state bits whose update rule is chosen by software or by a sequencer.

---
 rtl/ff_bank.sv | 87 ++++++++
 tb/tb_ff_bank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// Bank of WIDTH bistable state bits whose update rule (D, T, SR or JK) is selected
// at run time, with sticky illegal-SR error flags and a registered change pulse.
module ff_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] err,
  output logic             err_any,
  output logic             changed
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_e;

  mode_e            mode_q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] err_set;

  // Next state per bit. The mode in force is the one held before the edge, so a
  // mode write and an update on the same edge use the old rule.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    qn      = q;
    err_set = '0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (mode_q)
          MODE_D: qn[i] = a[i];
          MODE_T: qn[i] = a[i] ? ~q[i] : q[i];
          MODE_SR: begin
            unique case ({a[i], b[i]})
              2'b10:   qn[i] = 1'b1;
              2'b01:   qn[i] = 1'b0;
              2'b11:   err_set[i] = 1'b1;  // illegal: hold and flag
              default: qn[i] = q[i];
            endcase
          end
          MODE_JK: begin
            unique case ({a[i], b[i]})
              2'b10:   qn[i] = 1'b1;
              2'b01:   qn[i] = 1'b0;
              2'b11:   qn[i] = ~q[i];
              default: qn[i] = q[i];
            endcase
          end
          default: qn[i] = q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (rst) begin
      q       <= RST_VAL;
      mode_q  <= MODE_SR;
      err     <= '0;
      changed <= 1'b0;
    end else begin
      if (cfg_we) mode_q <= mode_e'(cfg_mode);
      q       <= qn;
      // A new illegal event on the clearing edge wins for its own bit.
      err     <= err_clr ? err_set : (err | err_set);
      changed <= en & (|(qn ^ q));
    end
  end

  assign q_bar   = ~q;
  assign mode    = mode_q;
  assign err_any = |err;

endmodule

// File: tb/tb_ff_bank.sv
// Directed testbench for ff_bank (WIDTH = 8, RST_VAL = 8'hA5) with hand-computed
// expected values; outputs are sampled 1 time unit after the rising edge.
module tb_ff_bank;

  localparam int         WIDTH   = 8;
  localparam logic [7:0] RST_VAL = 8'hA5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_mode = 2'b00;
  logic             en = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [1:0]       mode;
  logic [WIDTH-1:0] err;
  logic             err_any;
  logic             changed;

  int n_checks = 0;
  int n_fail   = 0;

  ff_bank #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .en(en),
    .a(a), .b(b), .err_clr(err_clr), .q(q), .q_bar(q_bar), .mode(mode),
    .err(err), .err_any(err_any), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [7:0] av, input logic [7:0] bv);
    en = e; a = av; b = bv;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_q: got %h expected a5", q); end
    n_checks++; if (q_bar !== 8'h5A) begin n_fail++; $display("FAIL reset_q_bar: got %h expected 5a", q_bar); end
    n_checks++; if (mode !== 2'd2) begin n_fail++; $display("FAIL reset_mode: got %0d expected 2", mode); end
    n_checks++; if (err !== 8'h00) begin n_fail++; $display("FAIL reset_err: got %h expected 00", err); end
    n_checks++; if (err_any !== 1'b0) begin n_fail++; $display("FAIL reset_err_any: got %b expected 0", err_any); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b expected 0", changed); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sr();
    drive(1'b1, 8'hFF, 8'h00); step();
    n_checks++; if (q !== 8'hFF) begin n_fail++; $display("FAIL sr_set_q: got %h expected ff", q); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL sr_set_changed: got %b expected 1", changed); end
    drive(1'b1, 8'h00, 8'h0F); step();
    n_checks++; if (q !== 8'hF0) begin n_fail++; $display("FAIL sr_reset_q: got %h expected f0", q); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL sr_reset_changed: got %b expected 1", changed); end
    drive(1'b1, 8'h00, 8'h00); step();
    n_checks++; if (q !== 8'hF0) begin n_fail++; $display("FAIL sr_hold_q: got %h expected f0", q); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL sr_hold_changed: got %b expected 0", changed); end
    n_checks++; if (err !== 8'h00) begin n_fail++; $display("FAIL sr_err: got %h expected 00", err); end
  endtask

  task automatic test_illegal_sr();
    drive(1'b1, 8'h0F, 8'hF0); step();
    n_checks++; if (q !== 8'h0F) begin n_fail++; $display("FAIL ill_setup_q: got %h expected 0f", q); end
    drive(1'b1, 8'h03, 8'h03); step();
    n_checks++; if (q !== 8'h0F) begin n_fail++; $display("FAIL ill_hold_q: got %h expected 0f", q); end
    n_checks++; if (err !== 8'h03) begin n_fail++; $display("FAIL ill_err: got %h expected 03", err); end
    n_checks++; if (err_any !== 1'b1) begin n_fail++; $display("FAIL ill_err_any: got %b expected 1", err_any); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL ill_changed: got %b expected 0", changed); end
    err_clr = 1'b1;
    drive(1'b1, 8'h01, 8'h01); step();
    n_checks++; if (err !== 8'h01) begin n_fail++; $display("FAIL ill_clr_set_err: got %h expected 01", err); end
    n_checks++; if (q !== 8'h0F) begin n_fail++; $display("FAIL ill_clr_set_q: got %h expected 0f", q); end
    drive(1'b1, 8'h00, 8'h00); step();
    n_checks++; if (err !== 8'h00) begin n_fail++; $display("FAIL ill_clr_err: got %h expected 00", err); end
    n_checks++; if (err_any !== 1'b0) begin n_fail++; $display("FAIL ill_clr_err_any: got %b expected 0", err_any); end
    err_clr = 1'b0;
  endtask

  task automatic test_mode_order();
    drive(1'b1, 8'h00, 8'hFF); step();
    n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL ord_setup_q: got %h expected 00", q); end
    cfg_we = 1'b1; cfg_mode = 2'b01;
    drive(1'b1, 8'hFF, 8'hFF); step();
    cfg_we = 1'b0;
    n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL ord_old_mode_q: got %h expected 00", q); end
    n_checks++; if (err !== 8'hFF) begin n_fail++; $display("FAIL ord_old_mode_err: got %h expected ff", err); end
    n_checks++; if (mode !== 2'd1) begin n_fail++; $display("FAIL ord_mode: got %0d expected 1", mode); end
    drive(1'b1, 8'hFF, 8'hFF); step();
    n_checks++; if (q !== 8'hFF) begin n_fail++; $display("FAIL ord_t_q: got %h expected ff", q); end
    n_checks++; if (err !== 8'hFF) begin n_fail++; $display("FAIL ord_t_err_sticky: got %h expected ff", err); end
    err_clr = 1'b1;
    drive(1'b0, 8'h00, 8'h00); step();
    err_clr = 1'b0;
    n_checks++; if (err !== 8'h00) begin n_fail++; $display("FAIL ord_clr_err: got %h expected 00", err); end
  endtask

  task automatic test_jk_d();
    cfg_we = 1'b1; cfg_mode = 2'b11;
    drive(1'b0, 8'h00, 8'h00); step();
    cfg_we = 1'b0;
    drive(1'b1, 8'hAA, 8'h55); step();
    n_checks++; if (q !== 8'hAA) begin n_fail++; $display("FAIL jk_setup_q: got %h expected aa", q); end
    drive(1'b1, 8'hFF, 8'hFF); step();
    n_checks++; if (q !== 8'h55) begin n_fail++; $display("FAIL jk_toggle_q: got %h expected 55", q); end
    n_checks++; if (err !== 8'h00) begin n_fail++; $display("FAIL jk_toggle_err: got %h expected 00", err); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL jk_toggle_changed: got %b expected 1", changed); end
    drive(1'b1, 8'h0F, 8'hF0); step();
    n_checks++; if (q !== 8'h0F) begin n_fail++; $display("FAIL jk_setreset_q: got %h expected 0f", q); end
    cfg_we = 1'b1; cfg_mode = 2'b00;
    drive(1'b0, 8'h00, 8'h00); step();
    cfg_we = 1'b0;
    n_checks++; if (q !== 8'h0F) begin n_fail++; $display("FAIL d_switch_q: got %h expected 0f", q); end
    drive(1'b1, 8'h3C, 8'hFF); step();
    n_checks++; if (q !== 8'h3C) begin n_fail++; $display("FAIL d_load_q: got %h expected 3c", q); end
    n_checks++; if (q_bar !== 8'hC3) begin n_fail++; $display("FAIL d_load_q_bar: got %h expected c3", q_bar); end
  endtask

  task automatic test_en_rst();
    cfg_we = 1'b1; cfg_mode = 2'b01;
    drive(1'b0, 8'h00, 8'h00); step();
    cfg_we = 1'b0;
    drive(1'b0, 8'hFF, 8'h00); step();
    n_checks++; if (q !== 8'h3C) begin n_fail++; $display("FAIL en_low_q: got %h expected 3c", q); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL en_low_changed: got %b expected 0", changed); end
    drive(1'b1, 8'hFF, 8'h00);
    cfg_we = 1'b1; cfg_mode = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL rst_mid_async_q: got %h expected a5", q); end
    step();
    n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL rst_mid_edge_q: got %h expected a5", q); end
    n_checks++; if (mode !== 2'd2) begin n_fail++; $display("FAIL rst_mid_mode: got %0d expected 2", mode); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL rst_mid_changed: got %b expected 0", changed); end
    rst = 1'b0; cfg_we = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sr();
    test_illegal_sr();
    test_mode_order();
    test_jk_d();
    test_en_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
